// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC register's next value, fetches over req/ack, hands off over valid/ready.
// Define FETCH_PERF_COUNT_EN to add the 32-bit fetch_count handshake counter output.
module instr_fetch_sequencer #(
  parameter int WIDTH   = 16,
  parameter int PC_STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_current,
  output logic [WIDTH-1:0] pc_next,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             stall
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]      fetch_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  state_t           state_reg;
  logic             mem_req_reg;
  logic             instr_valid_reg;
  logic [WIDTH-1:0] instr_reg;
  logic [WIDTH-1:0] addr_reg;
  logic             in_fetch;
  logic             fetch_done;
  logic             handshake;

  assign in_fetch    = (state_reg == REQ) || (state_reg == WAIT);
  assign fetch_done  = in_fetch && mem_ack;
  assign handshake   = instr_valid_reg && instr_ready;
  assign mem_req     = mem_req_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  // The first request cycle addresses the live PC; later cycles replay the captured address,
  // which keeps DRAIN pointing at the old fetch even after a branch has moved the PC.
  assign mem_addr    = (state_reg == REQ) ? pc_current : addr_reg;

  always_comb begin
    pc_next = pc_current;
    if (reset)
      pc_next = '0;
    else if (branch_valid)
      pc_next = branch_target;
    else if (fetch_done)
      pc_next = pc_current + STEP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      mem_req_reg     <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      addr_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!branch_valid && !stall) begin
            state_reg   <= REQ;
            mem_req_reg <= 1'b1;
          end
        end
        REQ, WAIT: begin
          if (state_reg == REQ)
            addr_reg <= pc_current;
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            if (branch_valid) begin
              state_reg <= IDLE;
            end else begin
              instr_reg       <= mem_rdata;
              instr_valid_reg <= 1'b1;
              state_reg       <= HOLD;
            end
          end else begin
            state_reg <= branch_valid ? DRAIN : WAIT;
          end
        end
        HOLD: begin
          if (branch_valid) begin
            instr_valid_reg <= 1'b0;
            state_reg       <= IDLE;
          end else if (instr_ready) begin
            instr_valid_reg <= 1'b0;
            if (!stall) begin
              state_reg   <= REQ;
              mem_req_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DRAIN: begin
          // A retired request ends the drain even if a new branch arrives with the ack.
          if (mem_ack) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count_reg;

  always_ff @(posedge clock) begin
    if (reset)
      fetch_count_reg <= '0;
    else if (handshake)
      fetch_count_reg <= fetch_count_reg + 32'd1;
  end

  assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed scenarios plus randomized traffic against a transaction-level model.
module tb_instr_fetch_sequencer;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] pc_current;
  logic [W-1:0] pc_next;
  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] instr;
  logic         instr_valid;
  logic         instr_ready;
  logic         branch_valid;
  logic [W-1:0] branch_target;
  logic         stall;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0]  fetch_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: is a request outstanding, is its response to be thrown away, is an instruction on offer.
  logic         m_out, m_drop, m_valid;
  logic [W-1:0] m_addr, m_instr, m_pc;
  logic [31:0]  m_count;

  instr_fetch_sequencer #(.WIDTH(W), .PC_STEP(1)) dut (
    .clock(clock), .reset(reset), .pc_current(pc_current), .pc_next(pc_next),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target), .stall(stall)
`ifdef FETCH_PERF_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clock = ~clock;

  // The PC register loads pc_next every clock.
  always @(posedge clock) pc_current <= pc_next;

  function automatic logic [W-1:0] exp_pc_next();
    if (reset) return '0;
    if (branch_valid) return branch_target;
    if (m_out && !m_drop && mem_ack) return m_pc + 16'd1;
    return m_pc;
  endfunction

  task automatic drive(input logic br, input logic [W-1:0] tg, input logic st,
                       input logic ak, input logic [W-1:0] rd, input logic rdy);
    branch_valid  = br;
    branch_target = tg;
    stall         = st;
    mem_ack       = ak;
    mem_rdata     = rd;
    instr_ready   = rdy;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    logic [W-1:0] pn;
    bit issue;
    pn    = exp_pc_next();
    issue = 0;
    if (reset) begin
      m_out = 0; m_drop = 0; m_valid = 0; m_instr = '0; m_count = '0;
    end else if (m_out) begin
      if (mem_ack) begin
        m_out = 0;
        if (!m_drop && !branch_valid) begin
          m_valid = 1;
          m_instr = mem_rdata;
        end
      end else if (branch_valid) begin
        m_drop = 1;
      end
    end else if (m_valid) begin
      if (instr_ready) m_count = m_count + 32'd1;
      if (branch_valid || instr_ready) m_valid = 0;
      if (!branch_valid && instr_ready && !stall) issue = 1;
    end else if (!branch_valid && !stall) begin
      issue = 1;
    end
    @(posedge clock);
    #1;
    m_pc = pn;
    if (issue) begin
      m_out  = 1;
      m_drop = 0;
      m_addr = pn;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
    tick();
    tick();
    n_cmp++; if (pc_next !== 16'h0000) begin n_fail++; $display("FAIL reset_pc_next: got %h expected 0000", pc_next); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int n_addr, last_hs;
    logic [W-1:0] exp_addr;
    do_reset();
    n_addr = 0; last_hs = -1; exp_addr = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, '0, 1'b0, 1'b1, W'($urandom), 1'b1);
      if (mem_req === 1'b1) begin
        n_cmp++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL stream_addr: got %h expected %h", mem_addr, exp_addr); end
        exp_addr = exp_addr + 16'd1;
        n_addr++;
      end
      if (instr_valid === 1'b1) begin
        n_cmp++; if (instr !== m_instr) begin n_fail++; $display("FAIL stream_instr: got %h expected %h", instr, m_instr); end
        if (last_hs >= 0) begin
          n_cmp++; if (c - last_hs != 2) begin n_fail++; $display("FAIL stream_spacing: got %0d expected 2", c - last_hs); end
        end
        last_hs = c;
      end
      n_cmp++; if (pc_next !== exp_pc_next()) begin n_fail++; $display("FAIL stream_pc_next: got %h expected %h", pc_next, exp_pc_next()); end
      tick();
    end
    n_cmp++; if (n_addr != 4) begin n_fail++; $display("FAIL stream_req_count: got %0d expected 4", n_addr); end
  endtask

  task automatic test_wait_and_hold();
    logic [W-1:0] rd;
    do_reset();
    drive(1'b1, 16'h0010, 1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    rd = W'($urandom);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b0, k == 3, (k == 3) ? rd : W'($urandom), 1'b1);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req k=%0d: got %b expected 1", k, mem_req); end
      n_cmp++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL wait_addr k=%0d: got %h expected 0010", k, mem_addr); end
      if (k == 3) begin
        n_cmp++; if (pc_next !== 16'h0011) begin n_fail++; $display("FAIL wait_pc_inc: got %h expected 0011", pc_next); end
      end
      tick();
    end
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid: got %b expected 1", instr_valid); end
    n_cmp++; if (instr !== rd) begin n_fail++; $display("FAIL wait_instr: got %h expected %h", instr, rd); end
    n_cmp++; if (pc_current !== 16'h0011) begin n_fail++; $display("FAIL wait_pc: got %h expected 0011", pc_current); end
    // Decode not ready for 5 cycles: everything must hold.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, W'($urandom), 1'b0);
      n_cmp++; if (instr_valid !== 1'b1 || instr !== rd) begin n_fail++; $display("FAIL hold_instr k=%0d: got %b/%h expected 1/%h", k, instr_valid, instr, rd); end
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req k=%0d: got %b expected 0", k, mem_req); end
      n_cmp++; if (pc_next !== 16'h0011) begin n_fail++; $display("FAIL hold_pc k=%0d: got %h expected 0011", k, pc_next); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0011) begin n_fail++; $display("FAIL hold_next_req: got %b/%h expected 1/0011", mem_req, mem_addr); end
  endtask

  task automatic test_branch_drain();
    do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();
    drive(1'b1, 16'h0200, 1'b0, 1'b0, '0, 1'b1);
    n_cmp++; if (pc_next !== 16'h0200) begin n_fail++; $display("FAIL drain_pc_next: got %h expected 0200", pc_next); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0, k == 2, W'($urandom), 1'b1);
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL drain_req k=%0d: got %b/%h expected 1/0000", k, mem_req, mem_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid k=%0d: got %b expected 0", k, instr_valid); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got %b/%b expected 0/0", mem_req, instr_valid); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin n_fail++; $display("FAIL drain_target_req: got %b/%h expected 1/0200", mem_req, mem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 16'h1234, 1'b1);
    n_cmp++; if (mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr: got %h expected ffff", mem_addr); end
    n_cmp++; if (pc_next !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc_next: got %h expected 0000", pc_next); end
    tick();
    n_cmp++; if (pc_current !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0000", pc_current); end
  endtask

`ifdef FETCH_PERF_COUNT_EN
  task automatic test_perf_count();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, '0, 1'b0, 1'b1, W'($urandom), 1'b1);
      tick();
    end
    n_cmp++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL perf_count: got %0d expected 3", fetch_count); end
    // Now in REQ: leave it unacked to reach WAIT, then reset with an ack in flight.
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 16'hABCD, 1'b1);
    tick();
    n_cmp++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL perf_reset_count: got %0d expected 0", fetch_count); end
    n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 || pc_next !== 16'h0000)
      begin n_fail++; $display("FAIL perf_reset_outputs: got %b/%b/%h/%h expected 0/0/0000/0000", mem_req, instr_valid, instr, pc_next); end
    reset = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(199) == 0);
      drive($urandom_range(9) == 0, W'($urandom), $urandom_range(3) == 0,
            m_out && ($urandom_range(4) < 2), W'($urandom), $urandom_range(1) == 1);
      n_cmp++; if (mem_req !== m_out) begin n_fail++; $display("FAIL rand_req c=%0d: got %b expected %b", c, mem_req, m_out); end
      if (m_out) begin
        n_cmp++; if (mem_addr !== m_addr) begin n_fail++; $display("FAIL rand_addr c=%0d: got %h expected %h", c, mem_addr, m_addr); end
      end
      n_cmp++; if (instr_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, instr_valid, m_valid); end
      n_cmp++; if (instr !== m_instr) begin n_fail++; $display("FAIL rand_instr c=%0d: got %h expected %h", c, instr, m_instr); end
      n_cmp++; if (pc_next !== exp_pc_next()) begin n_fail++; $display("FAIL rand_pc_next c=%0d: got %h expected %h", c, pc_next, exp_pc_next()); end
`ifdef FETCH_PERF_COUNT_EN
      n_cmp++; if (fetch_count !== m_count) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, fetch_count, m_count); end
`endif
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    m_out = 0; m_drop = 0; m_valid = 0;
    m_addr = '0; m_instr = '0; m_pc = '0; m_count = '0;
    test_reset();
    test_stream();
    test_wait_and_hold();
    test_branch_drain();
    test_wrap();
`ifdef FETCH_PERF_COUNT_EN
    test_perf_count();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

- Consumer of the PC register and generator of its next value.
- Reads the current PC and fetches the addressed word from instruction memory over a req/ack handshake.
- Presents the fetched instruction to decode over a valid/ready handshake.
- Drives the PC register's next-value input: increment, hold, or branch redirect.

## Interface
Parameters:
- WIDTH, 16, PC, address and instruction width.
- PC_STEP, 1, increment applied per accepted fetch; the PC is word-addressed.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- pc_current  in  WIDTH  current PC from the PC register.
- pc_next  out  WIDTH  next PC to the PC register, which loads it every clock.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  WIDTH  read address.
- mem_ack  in  1  read data valid and request retired.
- mem_rdata  in  WIDTH  read data.
- instr  out  WIDTH  fetched instruction to decode.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  decode accepts instr.
- branch_valid  in  1  single-cycle redirect request.
- branch_target  in  WIDTH  redirect address.
- stall  in  1  suppresses issue of new requests.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- Reset values: state IDLE, mem_req 0, instr_valid 0, instr 0, pc_next 0.
- Default: pc_next = pc_current, so the PC register holds its value.
- IDLE: if stall=0, go to REQ next cycle.
- REQ/WAIT: mem_req=1, mem_addr=pc_current.
  - mem_ack may arrive in the first REQ cycle.
  - Without ack, go to WAIT and hold mem_req and mem_addr stable until ack.
  - On ack: instr <= mem_rdata, instr_valid <= 1, pc_next = pc_current + PC_STEP in that cycle, go to HOLD.
- HOLD: instr_valid=1 and instr held stable until instr_ready=1.
  - On handshake: instr_valid <= 0, then go to REQ if stall=0, otherwise IDLE.
- Branch: branch_valid has priority over stall, increment and hold in every state.
  - pc_next = branch_target in the branch cycle.
  - instr_valid <= 0 next cycle. If the branch lands in the HOLD handshake cycle, that handshake still counts as accepted.
  - In REQ/WAIT without ack the request is still outstanding, so go to DRAIN. In REQ/WAIT with ack the same cycle, the data is discarded and the state moves to IDLE.
  - Otherwise go to IDLE.
- DRAIN: mem_req=1 and mem_addr held until ack. The response is discarded, instr_valid stays 0, then go to IDLE.
- A branch in DRAIN updates pc_next again and stays in DRAIN.
- Arithmetic is modulo 2^WIDTH: 0xFFFF + 1 = 0x0000, with no error flag.
- stall never aborts an outstanding request.

## Timing
- Per instruction, with zero-wait memory and an always-ready decode: REQ (ack) → HOLD (handshake) → REQ, i.e. 2 cycles.
- The PC register updates on the edge that ends the ack cycle. The next REQ therefore addresses PC+PC_STEP.
- instr_valid rises on the edge after the ack.
- Branch-to-first-request latency: 2 cycles (branch cycle, then IDLE, then REQ). DRAIN cycles are added on top.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and an in-flight ack is ignored. Memory must tolerate mem_req dropping without an ack.

## Configuration
- FETCH_PERF_COUNT_EN defined:
  - Adds output fetch_count (32 bits).
  - Reset value 0.
  - Increments once per instr_valid && instr_ready handshake and wraps at 2^32.
- FETCH_PERF_COUNT_EN undefined: no port and no counter logic.

## Test plan
- Zero-wait memory, ready=1, PC 0x0000 → mem_addr sequence 0x0000, 0x0001, 0x0002, with a handshake every 2 cycles.
- mem_ack delayed 3 cycles at PC 0x0010 → mem_req and mem_addr stable for 4 cycles; instr = rdata; PC becomes 0x0011 after the ack.
- instr_ready low for 5 cycles → instr and instr_valid stable; no mem_req; pc_next = pc_current.
- branch_valid (target 0x0200) during WAIT → DRAIN discards the response with instr_valid 0, and the next mem_addr is 0x0200.
- PC 0xFFFF fetch acked → PC becomes 0x0000. With the macro, 3 handshakes give fetch_count=3, and reset mid-WAIT returns all outputs to 0.
